// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_t   : fetch FSM states
//   INSN_BYTES      : bytes per instruction word (address step)
//   FETCH_BUF_DEPTH : entries in the fetched-word buffer
package mips_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      STALL,
      DISCARD,
      FAULT
   } fetch_state_t;

   localparam int unsigned INSN_BYTES      = 4;
   localparam int unsigned FETCH_BUF_DEPTH = 2;
   localparam int unsigned FETCH_CNT_W     = $clog2(FETCH_BUF_DEPTH + 1);
   localparam int unsigned FETCH_PTR_W     = $clog2(FETCH_BUF_DEPTH);

endpackage

// File: rtl/ins_fetch_if.sv
// Bundle of the fetch unit's branch, memory and decode-side signals.
//   master : the fetch unit (drives memory request and decode outputs)
//   slave  : the environment (PC/branch logic, instruction memory, decode)
interface ins_fetch_if;

   logic        redirect;
   logic [31:0] redirect_addr;
   logic [31:0] newInsAddress;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins_data;
   logic [31:0] InsAddress;
   logic        align_fault;

   modport master (
      input  redirect, redirect_addr, imem_ack, imem_rdata, ins_ready,
      output newInsAddress, imem_req, imem_addr, ins_valid, ins_data,
             InsAddress, align_fault
   );

   modport slave (
      output redirect, redirect_addr, imem_ack, imem_rdata, ins_ready,
      input  newInsAddress, imem_req, imem_addr, ins_valid, ins_data,
             InsAddress, align_fault
   );

endinterface

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {address, data} entries.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_entry at the tail
//   pop        : drop the head (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop
//   head       : entry at the head ({addr, data})
//   valid      : FIFO not empty
//   count      : number of stored entries
module fetch_buf
   import mips_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [63:0]            push_entry,
   output logic [63:0]            head,
   output logic                   valid,
   output logic [FETCH_CNT_W-1:0] count
);

   logic [63:0]            mem [FETCH_BUF_DEPTH];
   logic [FETCH_PTR_W-1:0] rd_ptr;
   logic [FETCH_PTR_W-1:0] wr_ptr;
   logic                   do_pop;
   logic                   do_push;

   assign valid   = (count != '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && valid;
   // A push into a full buffer is only legal alongside a pop.
   assign do_push = push && ((count != FETCH_CNT_W'(FETCH_BUF_DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < FETCH_BUF_DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + FETCH_PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + FETCH_PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + FETCH_CNT_W'(1);
            2'b01:   count <= count - FETCH_CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ins_fetch.sv
// Instruction-fetch front end: generates the fetch address stream, issues
// reads over a req/ack handshake and buffers returned words for decode.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : ins_fetch_if.master (redirect, memory req/ack, decode valid/ready)
//   RESET_ADDR : word-aligned fetch address after reset
// Build option: define ALIGN_TRAP_EN to trap misaligned redirects into a
// sticky FAULT state; otherwise redirect_addr[1:0] is forced to zero.
module ins_fetch
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
)(
   input  logic         CLK,
   input  logic         RST,
   ins_fetch_if.master  bus
);

   fetch_state_t           state, state_nx;
   logic [31:0]            npc, npc_nx;
   logic [31:0]            hold_addr, hold_addr_nx;
   logic [31:0]            target;
   logic                   misaligned;
   logic                   req, push, pop, flush;
   logic [FETCH_CNT_W-1:0] count;
   logic [63:0]            head;
   logic                   valid;
   int unsigned            cnt_after;

`ifdef ALIGN_TRAP_EN
   assign target      = bus.redirect_addr;
   assign misaligned  = (bus.redirect_addr[1:0] != 2'b00);
   assign bus.align_fault = (state == FAULT);
`else
   assign target      = {bus.redirect_addr[31:2], 2'b00};
   assign misaligned  = 1'b0;
   assign bus.align_fault = 1'b0;
`endif

   assign pop       = valid && bus.ins_ready;
   // Occupancy after this cycle's push, used to decide FETCH vs STALL.
   assign cnt_after = 32'(count) + 32'd1 - 32'(pop);

   always_comb begin
      state_nx     = state;
      npc_nx       = npc;
      hold_addr_nx = hold_addr;
      push         = 1'b0;
      flush        = 1'b0;
      req          = (state == FETCH) || (state == DISCARD);

      case (state)
         IDLE:    state_nx = FETCH;
         FETCH: begin
            if (bus.imem_ack) begin
               push   = 1'b1;
               npc_nx = npc + 32'(INSN_BYTES);
               if (cnt_after >= FETCH_BUF_DEPTH) state_nx = STALL;
            end
         end
         STALL:   if (pop) state_nx = FETCH;
         DISCARD: if (bus.imem_ack) state_nx = FETCH;
         FAULT:   ;
         default: state_nx = IDLE;
      endcase

      // Redirect overrides whatever the state decided above, including
      // dropping a word acked in the same cycle.
      if (bus.redirect && (state != FAULT)) begin
         flush  = 1'b1;
         push   = 1'b0;
         npc_nx = target;
         if (misaligned) begin
            state_nx = FAULT;
         end else if (req && !bus.imem_ack) begin
            // Keep presenting the in-flight address until memory acks it.
            state_nx     = DISCARD;
            hold_addr_nx = bus.imem_addr;
         end else begin
            state_nx = FETCH;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         npc       <= RESET_ADDR;
         hold_addr <= RESET_ADDR;
      end else begin
         state     <= state_nx;
         npc       <= npc_nx;
         hold_addr <= hold_addr_nx;
      end
   end

   fetch_buf u_buf (
      .clk        (CLK),
      .rst        (RST),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .push_entry ({npc, bus.imem_rdata}),
      .head       (head),
      .valid      (valid),
      .count      (count)
   );

   assign bus.newInsAddress = npc;
   assign bus.imem_req      = req;
   assign bus.imem_addr     = (state == DISCARD) ? hold_addr : npc;
   assign bus.ins_valid     = valid;
   assign bus.InsAddress    = head[63:32];
   assign bus.ins_data      = head[31:0];

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed scenarios plus a randomized
// run scored against an in-order delivery model (each delivered word must
// be the next sequential address since the last redirect, data = addr+100).
module tb_ins_fetch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ins_fetch_if bus ();

   ins_fetch #(.RESET_ADDR(32'h0000_0000)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [31:0] req_log[$];
   int          req_cyc[$];
   logic [63:0] del_log[$];
   int          del_cyc[$];
   int          cyc;
   logic        pending;
   logic [31:0] held_addr;
   int unsigned mem_wait;
   int unsigned mem_lat;
   logic        rand_lat;
   logic        sb_en;
   logic [31:0] exp_next;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_addr = '0;
      bus.ins_ready = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_log.delete(); req_cyc.delete();
      del_log.delete(); del_cyc.delete();
      cyc = 0; pending = 1'b0; held_addr = '0; mem_wait = 0;
      mem_lat = 0; rand_lat = 1'b0; sb_en = 1'b0; exp_next = 32'h0;
   endtask

   // One clock cycle: apply decode/branch inputs, act as memory, log and
   // score, then advance to just after the next rising edge.
   task automatic step(input logic rdy, input logic redir, input logic [31:0] raddr);
      bus.ins_ready = rdy;
      bus.redirect = redir;
      bus.redirect_addr = raddr;
      if (bus.imem_req) begin
         if (pending) check("addr_hold", bus.imem_addr, held_addr);
         else begin
            req_log.push_back(bus.imem_addr);
            req_cyc.push_back(cyc);
            if (rand_lat) mem_lat = $urandom_range(0, 3);
         end
         if (mem_wait >= mem_lat) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = bus.imem_addr + 32'd100;
            mem_wait = 0;
         end else begin
            bus.imem_ack = 1'b0;
            mem_wait++;
         end
         pending = !bus.imem_ack;
         held_addr = bus.imem_addr;
      end else begin
         bus.imem_ack = 1'b0;
         pending = 1'b0;
         mem_wait = 0;
      end
      if (bus.ins_valid && rdy) begin
         del_log.push_back({bus.InsAddress, bus.ins_data});
         del_cyc.push_back(cyc);
         if (sb_en) begin
            check("sb_addr", bus.InsAddress, exp_next);
            check("sb_data", bus.ins_data, exp_next + 32'd100);
            exp_next = exp_next + 32'd4;
         end
      end
      if (redir && sb_en) exp_next = {raddr[31:2], 2'b00};
      @(posedge clk);
      #1;
      cyc++;
      bus.redirect = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values and zero-wait streaming
      do_reset();
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_imem_addr", bus.imem_addr, 32'h0);
      check("rst_npc", bus.newInsAddress, 32'h0);
      check("rst_valid", 32'(bus.ins_valid), 32'd0);
      check("rst_data", bus.ins_data, 32'h0);
      check("rst_insaddr", bus.InsAddress, 32'h0);
      check("rst_fault", 32'(bus.align_fault), 32'd0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
      for (int k = 0; k < 3; k++) begin
         check("s1_req_addr", req_log[k], 32'(4 * k));
         check("s1_req_cyc", 32'(req_cyc[k]), 32'(k + 1));
         check("s1_del_addr", del_log[k][63:32], 32'(4 * k));
         check("s1_del_data", del_log[k][31:0], 32'(4 * k + 100));
         check("s1_del_cyc", 32'(del_cyc[k]), 32'(k + 2));
      end

      // ---- back-pressure: buffer fills, exactly one refill per pop
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
      check("s2_nreq", 32'(req_log.size()), 32'd2);
      check("s2_req_low", 32'(bus.imem_req), 32'd0);
      check("s2_valid", 32'(bus.ins_valid), 32'd1);
      check("s2_head", bus.InsAddress, 32'h0);
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
      check("s2_nreq2", 32'(req_log.size()), 32'd3);
      check("s2_req3", req_log[2], 32'h8);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0);
      check("s2_del1", del_log[1][63:32], 32'h4);
      check("s2_del2", del_log[2][63:32], 32'h8);

      // ---- redirect while a slow request is outstanding
      do_reset();
      mem_lat = 3;
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 32'h40);
      check("s3_hold_addr", bus.imem_addr, 32'h0);
      check("s3_hold_req", 32'(bus.imem_req), 32'd1);
      check("s3_npc", bus.newInsAddress, 32'h40);
      check("s3_flushed", 32'(bus.ins_valid), 32'd0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
      check("s3_req0", req_log[0], 32'h0);
      check("s3_req1", req_log[1], 32'h40);
      check("s3_req1_cyc", 32'(req_cyc[1]), 32'd5);
      check("s3_del0_addr", del_log[0][63:32], 32'h40);
      check("s3_del0_data", del_log[0][31:0], 32'h40 + 32'd100);

      // ---- redirect in the same cycle as an ack
      do_reset();
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 32'h80);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
      check("s4_req1", req_log[1], 32'h4);
      check("s4_req2", req_log[2], 32'h80);
      check("s4_req2_cyc", 32'(req_cyc[2]), 32'd3);
      check("s4_del0", del_log[0][63:32], 32'h0);
      check("s4_del1", del_log[1][63:32], 32'h80);

      // ---- address wrap at the top of the address space
      do_reset();
      step(1'b1, 1'b1, 32'hFFFF_FFFC);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
      check("s5_req0", req_log[0], 32'hFFFF_FFFC);
      check("s5_req1", req_log[1], 32'h0);
      check("s5_del0_data", del_log[0][31:0], 32'h0000_0060);
      check("s5_del1_addr", del_log[1][63:32], 32'h0);

      // ---- misaligned redirect
      do_reset();
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 32'h42);
`ifdef ALIGN_TRAP_EN
      check("s6_fault", 32'(bus.align_fault), 32'd1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
      check("s6_nreq", 32'(req_log.size()), 32'd1);
      check("s6_req_low", 32'(bus.imem_req), 32'd0);
      check("s6_valid", 32'(bus.ins_valid), 32'd0);
      check("s6_fault_held", 32'(bus.align_fault), 32'd1);
      do_reset();
      check("s6_fault_clr", 32'(bus.align_fault), 32'd0);
`else
      check("s6_nofault", 32'(bus.align_fault), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
      check("s6_req1", req_log[1], 32'h40);
      check("s6_del0", del_log[0][63:32], 32'h40);
`endif

      // ---- randomized traffic against the in-order delivery model
      do_reset();
      sb_en = 1'b1;
      rand_lat = 1'b1;
      for (int i = 0; i < 800; i++) begin
         logic        r;
         logic        rd;
         logic [31:0] ta;
         r  = ($urandom_range(0, 3) != 0);
         rd = ($urandom_range(0, 19) == 0);
         ta = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                          : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         step(r, rd, ta);
      end
      check("rnd_progress", 32'(del_log.size() >= 50), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
